flappy_scheduler: RTL and testbench

//  Game sequencer for the scrolling pipe matrix. Owns the IDLE/PLAY/OVER flow and

---
 rtl/flappy_if.sv | 22 ++
 rtl/flappy_scheduler.sv | 150 +++++++++++++++
 tb/tb_flappy_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flappy_if.sv
// Handshake bundle between the game sequencer and its neighbours
// (keys, bird block, shift matrix).
interface flappy_if;
   logic       key_start;
   logic [7:0] bird_row;
   logic [7:0] col_at_bird;
   logic       start;
   logic       over;
   logic       shift_en;
   logic [7:0] pattern;
   logic [7:0] score;

   modport master (
      output key_start, bird_row, col_at_bird,
      input  start, over, shift_en, pattern, score
   );

   modport slave (
      input  key_start, bird_row, col_at_bird,
      output start, over, shift_en, pattern, score
   );
endinterface

// File: rtl/flappy_scheduler.sv
// Game sequencer: IDLE/PLAY/OVER flow, scroll strobe with score-driven speed,
// random pipe-column generation and bird/pipe collision detection.
module flappy_scheduler #(
   parameter int BASE_DIV     = 255,
   parameter int DIV_STEP     = 16,
   parameter int MIN_DIV      = 63,
   parameter int PIPE_SPACING = 4,
   parameter int GAP_H        = 3
) (
   input  logic     clk,
   input  logic     reset,
   flappy_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam logic [7:0] BASE_DIV_C  = 8'(BASE_DIV);
   localparam logic [7:0] MIN_DIV_C   = 8'(MIN_DIV);
   localparam logic [7:0] PIPE_LAST_C = 8'(PIPE_SPACING - 1);
   localparam logic [7:0] GAP_ONES_C  = 8'((1 << GAP_H) - 1);
   localparam logic [7:0] GAP_POS_C   = 8'(9 - GAP_H);
   localparam logic [7:0] LFSR_SEED_C = 8'hA5;

   // x^8+x^6+x^5+x^4+1; the all-zero state is unreachable from a non-zero seed
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Speed level lowers the reload by DIV_STEP per level, floored at MIN_DIV
   function automatic logic [7:0] reload_for(input logic [5:0] level);
      logic [15:0] dec;
      dec = 16'(level) * 16'(DIV_STEP);
      if (dec + 16'(MIN_DIV) >= 16'(BASE_DIV)) begin
         return MIN_DIV_C;
      end else begin
         return 8'(16'(BASE_DIV) - dec);
      end
   endfunction

   state_t     state_q, state_d;
   logic       start_q, start_d;
   logic       over_q, over_d;
   logic       shift_en_q, shift_en_d;
   logic [7:0] pattern_q, pattern_d;
   logic [7:0] score_q, score_d;
   logic [7:0] div_cnt_q, div_cnt_d;
   logic [7:0] pipe_cnt_q, pipe_cnt_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] gap_mask_s;
   logic       hit_s;

   assign gap_mask_s = GAP_ONES_C << (lfsr_q % GAP_POS_C);
   assign hit_s      = (|(bus.col_at_bird & bus.bird_row)) | (bus.bird_row == 8'h00);

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      score_d    = score_q;
      div_cnt_d  = div_cnt_q;
      pipe_cnt_d = pipe_cnt_q;
      shift_en_d = 1'b0;
      lfsr_d     = lfsr_step(lfsr_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.key_start) begin
               state_d    = ST_PLAY;
               score_d    = 8'h00;
               div_cnt_d  = BASE_DIV_C;
               pipe_cnt_d = PIPE_LAST_C;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_PLAY: begin
            // A collision wins over a strobe that is due on the same edge
            if (hit_s) begin
               state_d = ST_OVER;
            end else if (div_cnt_q == 8'h00) begin
               shift_en_d = 1'b1;
               div_cnt_d  = reload_for(score_q[7:2]);
               if (pipe_cnt_q == 8'h00) begin
                  pattern_d  = ~gap_mask_s;
                  pipe_cnt_d = PIPE_LAST_C;
               end else begin
                  pattern_d  = 8'h00;
                  pipe_cnt_d = pipe_cnt_q - 8'h01;
               end
               if ((bus.col_at_bird != 8'h00) && (score_q != 8'hFF)) begin
                  score_d = score_q + 8'h01;
               end else begin
                  score_d = score_q;
               end
            end else begin
               div_cnt_d = div_cnt_q - 8'h01;
            end
         end
         ST_OVER: begin
            if (bus.key_start) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OVER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      start_d = (state_d != ST_IDLE);
      over_d  = (state_d == ST_OVER);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         over_q     <= 1'b0;
         shift_en_q <= 1'b0;
         pattern_q  <= 8'h00;
         score_q    <= 8'h00;
         div_cnt_q  <= BASE_DIV_C;
         pipe_cnt_q <= PIPE_LAST_C;
         lfsr_q     <= LFSR_SEED_C;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         over_q     <= over_d;
         shift_en_q <= shift_en_d;
         pattern_q  <= pattern_d;
         score_q    <= score_d;
         div_cnt_q  <= div_cnt_d;
         pipe_cnt_q <= pipe_cnt_d;
         lfsr_q     <= lfsr_d;
      end
   end

   assign bus.start    = start_q;
   assign bus.over     = over_q;
   assign bus.shift_en = shift_en_q;
   assign bus.pattern  = pattern_q;
   assign bus.score    = score_q;

endmodule

// File: tb/tb_flappy_scheduler.sv
// Bench for flappy_scheduler: hand-computed vector table, corner-case sequences
// and randomized play checked against a game-level reference model.
module tb_flappy_scheduler;

   localparam int BASE_DIV     = 7;
   localparam int DIV_STEP     = 2;
   localparam int MIN_DIV      = 3;
   localparam int PIPE_SPACING = 4;
   localparam int GAP_H        = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   flappy_if bus();

   flappy_scheduler #(
      .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP), .MIN_DIV(MIN_DIV),
      .PIPE_SPACING(PIPE_SPACING), .GAP_H(GAP_H)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: game mode, edges left until the next scroll, scroll count
   int         m_mode;   // 0 idle, 1 play, 2 over
   int         m_wait;
   int         m_k;
   logic [7:0] m_lfsr, m_pat, m_score;
   logic       m_shift;

   function automatic int period_for(logic [7:0] sc);
      int r;
      r = BASE_DIV - (int'(sc) / 4) * DIV_STEP;
      if (r < MIN_DIV) r = MIN_DIV;
      return r + 1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_wait = 0; m_k = 0;
      m_lfsr = 8'hA5; m_pat = 8'h00; m_score = 8'h00; m_shift = 1'b0;
   endtask

   task automatic model_step();
      logic       hit;
      logic [7:0] gap;
      hit     = ((bus.bird_row & bus.col_at_bird) != 8'h00) || (bus.bird_row == 8'h00);
      m_shift = 1'b0;
      if (m_mode == 0) begin
         if (bus.key_start) begin
            m_mode = 1; m_score = 8'h00; m_wait = BASE_DIV + 1; m_k = 0;
         end
      end else if (m_mode == 1) begin
         if (hit) begin
            m_mode = 2;
         end else begin
            m_wait--;
            if (m_wait == 0) begin
               m_shift = 1'b1;
               m_wait  = period_for(m_score);
               gap     = 8'((1 << GAP_H) - 1) << (int'(m_lfsr) % (9 - GAP_H));
               m_pat   = ((m_k % PIPE_SPACING) == PIPE_SPACING - 1) ? ~gap : 8'h00;
               m_k++;
               if (bus.col_at_bird != 8'h00 && m_score != 8'hFF) m_score = m_score + 8'd1;
            end
         end
      end else begin
         if (bus.key_start) m_mode = 0;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   endtask

   task automatic check(string name, logic s, logic o, logic sh, logic pchk,
                        logic [7:0] pat, logic [7:0] sc);
      n_vec++;
      if (bus.start !== s || bus.over !== o || bus.shift_en !== sh ||
          (pchk && bus.pattern !== pat) || bus.score !== sc) begin
         n_bad++;
         $display("FAIL %s @%0t: got start=%b over=%b shift=%b pat=%h score=%h, want start=%b over=%b shift=%b pat=%h(chk=%b) score=%h",
                  name, $time, bus.start, bus.over, bus.shift_en, bus.pattern, bus.score,
                  s, o, sh, pat, pchk, sc);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("model", m_mode != 0, m_mode == 2, m_shift, 1'b1, m_pat, m_score);
   endtask

   // Reset is asserted between edges so the async clear is observed at once
   task automatic do_reset(string name);
      reset = 1'b0;
      #1;
      model_reset();
      check(name, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   function automatic bit one_gap(logic [7:0] p);
      logic [7:0] x;
      int ones, first, last;
      x = ~p; ones = 0; first = -1; last = -1;
      for (int i = 0; i < 8; i++) begin
         if (x[i]) begin
            ones++;
            if (first < 0) first = i;
            last = i;
         end
      end
      return (ones == GAP_H) && (last - first == GAP_H - 1);
   endfunction

   typedef struct {
      int         reps;
      logic       key;
      logic [7:0] bird;
      logic [7:0] col;
      logic       s, o, sh, pchk;
      logic [7:0] pat;
      logic [7:0] sc;
   } vec_t;

   vec_t tbl [0:20];

   initial begin
      int since, last_gap, found;
      logic [7:0] c8;

      tbl[0]  = '{50, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
      tbl[1]  = '{ 1, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
      tbl[2]  = '{ 7, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
      tbl[3]  = '{ 1, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01};
      tbl[4]  = '{ 7, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01};
      tbl[5]  = '{ 1, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02};
      tbl[6]  = '{ 7, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02};
      tbl[7]  = '{ 1, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h03};
      tbl[8]  = '{ 7, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h03};
      tbl[9]  = '{ 1, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04};
      tbl[10] = '{ 7, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04};
      tbl[11] = '{ 1, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05};
      tbl[12] = '{ 5, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h05};
      tbl[13] = '{ 1, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h06};
      tbl[14] = '{ 1, 1'b0, 8'h10, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h06};
      tbl[15] = '{ 5, 1'b0, 8'h10, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h06};
      tbl[16] = '{ 1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h06};
      tbl[17] = '{ 3, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h06};
      tbl[18] = '{ 1, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
      tbl[19] = '{ 1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
      tbl[20] = '{ 1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};

      reset = 1'b0;
      bus.key_start = 1'b0; bus.bird_row = 8'h10; bus.col_at_bird = 8'h00;
      #2;
      do_reset("reset_init");

      // Directed table: idle, first scrolls, speed-up, collision, restart, fall-off
      for (int i = 0; i <= 20; i++) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            bus.key_start = tbl[i].key; bus.bird_row = tbl[i].bird; bus.col_at_bird = tbl[i].col;
            tick();
            check($sformatf("table[%0d]", i), tbl[i].s, tbl[i].o, tbl[i].sh, tbl[i].pchk,
                  tbl[i].pat, tbl[i].sc);
            if (bus.shift_en && bus.pattern != 8'h00) begin
               n_vec++;
               if (!one_gap(bus.pattern)) begin
                  n_bad++;
                  $display("FAIL pipe_gap table[%0d]: pattern=%h, want exactly %0d contiguous zeros", i, bus.pattern, GAP_H);
               end
            end
         end
      end
      bus.key_start = 1'b0;

      // Score saturation and minimum scroll period
      do_reset("reset_sat");
      bus.key_start = 1'b1; tick();
      bus.key_start = 1'b0; bus.bird_row = 8'h10; bus.col_at_bird = 8'h01;
      since = 0; last_gap = 0;
      repeat (1300) begin
         tick();
         since++;
         if (bus.shift_en) begin
            if (bus.score >= 8'd10) last_gap = since;
            since = 0;
         end
      end
      n_vec++;
      if (bus.score !== 8'hFF) begin
         n_bad++;
         $display("FAIL score_sat: score=%h, want ff", bus.score);
      end
      n_vec++;
      if (last_gap != MIN_DIV + 1) begin
         n_bad++;
         $display("FAIL min_period: period=%0d, want %0d", last_gap, MIN_DIV + 1);
      end

      // Randomized play against the model
      do_reset("reset_rand");
      repeat (3000) begin
         bus.key_start = ($urandom_range(0, 29) == 0);
         bus.bird_row  = ($urandom_range(0, 199) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
         c8 = 8'($urandom);
         case ($urandom_range(0, 99))
            99:      bus.col_at_bird = c8 | bus.bird_row;
            default: bus.col_at_bird = ($urandom_range(0, 1) == 0) ? 8'h00 : (c8 & ~bus.bird_row);
         endcase
         tick();
         if (bus.shift_en && bus.pattern != 8'h00) begin
            n_vec++;
            if (!one_gap(bus.pattern)) begin
               n_bad++;
               $display("FAIL pipe_gap random: pattern=%h, want exactly %0d contiguous zeros", bus.pattern, GAP_H);
            end
         end
      end

      // Reset asserted during a strobe cycle
      do_reset("reset_pre");
      bus.key_start = 1'b1; tick();
      bus.key_start = 1'b0; bus.bird_row = 8'h10; bus.col_at_bird = 8'h01;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         tick();
         if (bus.shift_en) found = 1;
      end
      n_vec++;
      if (found == 0) begin
         n_bad++;
         $display("FAIL strobe_timeout: shift_en=0 after 40 cycles, want a strobe");
      end
      do_reset("reset_mid_strobe");
      repeat (5) tick();
      check("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
